reuleaux_seq: RTL and testbench

//  Sequencer/filter upstream and downstream of the circle engine: latches a Reuleaux triangle request, computes

---
 rtl/reuleaux_seq.sv | 201 ++++++++++++++++++++
 tb/tb_reuleaux_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reuleaux_seq.sv
// Reuleaux triangle sequencer: derives three vertex centres, drives the circle engine once per
// vertex, and forwards only engine pixels that lie within radius d of both other vertices.
module reuleaux_seq #(
    parameter logic [15:0] K6 = 16'd18919,
    parameter logic [15:0] K3 = 16'd37838
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [7:0] centre_y,
    input  logic [7:0] diameter,
    output logic       finished,
    output logic       err,
    output logic       circ_start,
    output logic [7:0] circ_centre_x,
    output logic [7:0] circ_centre_y,
    output logic [7:0] circ_radius,
    input  logic       circ_finished,
    input  logic [7:0] circ_x,
    input  logic [6:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [3:0] {
        IDLE, CALC, CHECK, DRAW1, GAP1, DRAW2, GAP2, DRAW3, FLUSH, DONE
    } state_t;

    // state is kept as a named signal so checkers can bind to it hierarchically
    state_t state;

    logic [7:0]        cx_q, cy_q, d_q;
    logic signed [9:0] v1x, v1y, v2x, v2y, v3x, v3y;

    logic [8:0]        h6, h3;
    logic signed [9:0] cx_s, cy_s, hd_s, h6_s, h3_s;
    logic [15:0]       dsq;

    assign h6   = 9'((25'(d_q) * 25'(K6) + 25'd32768) >> 16);
    assign h3   = 9'((25'(d_q) * 25'(K3) + 25'd32768) >> 16);
    assign cx_s = signed'({2'b00, cx_q});
    assign cy_s = signed'({2'b00, cy_q});
    assign hd_s = signed'({3'b000, d_q[7:1]});
    assign h6_s = signed'({1'b0, h6});
    assign h3_s = signed'({1'b0, h3});
    assign dsq  = 16'(d_q) * 16'(d_q);

    function automatic logic in_reach(input logic [7:0] px, input logic [6:0] py,
                                      input logic signed [9:0] vx, input logic signed [9:0] vy,
                                      input logic [15:0] r2);
        logic signed [9:0]  dx, dy;
        logic signed [19:0] dx20, dy20;
        logic [19:0]        sx, sy;
        logic [20:0]        sum;
        dx   = signed'({2'b00, px}) - vx;
        dy   = signed'({3'b000, py}) - vy;
        dx20 = 20'(dx);
        dy20 = 20'(dy);
        sx   = 20'($unsigned(dx20 * dx20));
        sy   = 20'($unsigned(dy20 * dy20));
        sum  = {1'b0, sx} + {1'b0, sy};
        return sum <= {5'b00000, r2};
    endfunction

    function automatic logic off_screen(input logic signed [9:0] vx, input logic signed [9:0] vy);
        return (vx < 0) || (vx > 10'sd159) || (vy < 0) || (vy > 10'sd119);
    endfunction

    // The filter tests the current pixel against the two vertices not being drawn.
    logic signed [9:0] ax, ay, bx, by;
    logic              in_draw, keep;

    always_comb begin
        ax = v2x;
        ay = v2y;
        bx = v3x;
        by = v3y;
        case (state)
            DRAW2: begin
                ax = v1x; ay = v1y;
                bx = v3x; by = v3y;
            end
            DRAW3: begin
                ax = v1x; ay = v1y;
                bx = v2x; by = v2y;
            end
            default: ;
        endcase
    end

    assign in_draw = (state == DRAW1) || (state == DRAW2) || (state == DRAW3);
    assign keep    = in_reach(circ_x, circ_y, ax, ay, dsq) && in_reach(circ_x, circ_y, bx, by, dsq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            finished      <= 1'b0;
            err           <= 1'b0;
            circ_start    <= 1'b0;
            circ_centre_x <= 8'd0;
            circ_centre_y <= 8'd0;
            circ_radius   <= 8'd0;
            vga_x         <= 8'd0;
            vga_y         <= 7'd0;
            vga_colour    <= 3'd0;
            vga_plot      <= 1'b0;
            cx_q          <= 8'd0;
            cy_q          <= 8'd0;
            d_q           <= 8'd0;
            v1x <= '0; v1y <= '0;
            v2x <= '0; v2y <= '0;
            v3x <= '0; v3y <= '0;
        end else begin
            vga_x    <= circ_x;
            vga_y    <= circ_y;
            vga_plot <= circ_plot & keep & in_draw;
            case (state)
                IDLE: begin
                    if (start) begin
                        cx_q       <= centre_x;
                        cy_q       <= centre_y;
                        d_q        <= diameter;
                        vga_colour <= colour;
                        err        <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    v1x   <= cx_s + hd_s;
                    v1y   <= cy_s + h6_s;
                    v2x   <= cx_s - hd_s;
                    v2y   <= cy_s + h6_s;
                    v3x   <= cx_s;
                    v3y   <= cy_s - h3_s;
                    state <= CHECK;
                end
                CHECK: begin
                    if (off_screen(v1x, v1y) || off_screen(v2x, v2y) || off_screen(v3x, v3y)) begin
                        err      <= 1'b1;
                        finished <= 1'b1;
                        state    <= DONE;
                    end else begin
                        circ_start    <= 1'b1;
                        circ_centre_x <= v1x[7:0];
                        circ_centre_y <= v1y[7:0];
                        circ_radius   <= d_q;
                        state         <= DRAW1;
                    end
                end
                DRAW1: begin
                    if (circ_finished) begin
                        circ_start <= 1'b0;
                        state      <= GAP1;
                    end
                end
                GAP1: begin
                    circ_start    <= 1'b1;
                    circ_centre_x <= v2x[7:0];
                    circ_centre_y <= v2y[7:0];
                    state         <= DRAW2;
                end
                DRAW2: begin
                    if (circ_finished) begin
                        circ_start <= 1'b0;
                        state      <= GAP2;
                    end
                end
                GAP2: begin
                    circ_start    <= 1'b1;
                    circ_centre_x <= v3x[7:0];
                    circ_centre_y <= v3y[7:0];
                    state         <= DRAW3;
                end
                DRAW3: begin
                    if (circ_finished) begin
                        circ_start <= 1'b0;
                        state      <= FLUSH;
                    end
                end
                FLUSH: begin
                    finished <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!start) begin
                        finished <= 1'b0;
                        err      <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reuleaux_seq.sv
// Bench for reuleaux_seq: a stub circle engine feeds random pixels, and a vertex/distance model
// predicts which of them must reach the VGA port.
module tb_reuleaux_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] colour;
    logic [7:0] centre_x, centre_y, diameter;
    logic       finished, err;
    logic       circ_start;
    logic [7:0] circ_centre_x, circ_centre_y, circ_radius;
    logic       circ_finished;
    logic [7:0] circ_x;
    logic [6:0] circ_y;
    logic       circ_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    always #5 clk = ~clk;

    reuleaux_seq dut (
        .clk(clk), .rst(rst), .start(start), .colour(colour),
        .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
        .finished(finished), .err(err),
        .circ_start(circ_start), .circ_centre_x(circ_centre_x), .circ_centre_y(circ_centre_y),
        .circ_radius(circ_radius), .circ_finished(circ_finished),
        .circ_x(circ_x), .circ_y(circ_y), .circ_plot(circ_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [14:0] exp_q[$];
    int          vx[1:3], vy[1:3];
    int          m_d;
    logic [2:0]  m_colour;
    bit          m_err;
    int          n_plot, n_cstart, n_keep;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Geometry straight from the triangle definition, with the fixed-point sqrt(3) constants.
    task automatic model_vertices(input int cx, input int cy, input int d);
        int h6, h3;
        h6 = (d * 18919 + 32768) / 65536;
        h3 = (d * 37838 + 32768) / 65536;
        vx[1] = cx + d / 2; vy[1] = cy + h6;
        vx[2] = cx - d / 2; vy[2] = cy + h6;
        vx[3] = cx;         vy[3] = cy - h3;
        m_d   = d;
        m_err = 1'b0;
        for (int k = 1; k <= 3; k++)
            if (vx[k] < 0 || vx[k] > 159 || vy[k] < 0 || vy[k] > 119) m_err = 1'b1;
    endtask

    function automatic bit model_keep(input int i, input int x, input int y);
        for (int j = 1; j <= 3; j++)
            if (j != i && (x - vx[j]) * (x - vx[j]) + (y - vy[j]) * (y - vy[j]) > m_d * m_d)
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Every VGA strobe must match the oldest predicted pixel, in order.
    always @(negedge clk) begin
        logic [14:0] e;
        if (circ_start === 1'b1) n_cstart++;
        if (vga_plot === 1'b1) begin
            n_plot++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 15'h7fff;
            chk("vga_xy", 32'({vga_x, vga_y}), 32'(e));
            chk("vga_colour", 32'(vga_colour), 32'(m_colour));
        end
    end

    task automatic wait_circ_start(input string tag, output int waited);
        waited = 0;
        forever begin
            @(negedge clk);
            if (circ_start === 1'b1 || waited >= 100) break;
            waited++;
        end
        chk(tag, 32'(circ_start), 32'd1);
    endtask

    task automatic drive_pixel(input int i, input int x, input int y, input bit plot, input bit fin);
        circ_x        = 8'(x);
        circ_y        = 7'(y);
        circ_plot     = plot;
        circ_finished = fin;
        if (plot && model_keep(i, x, y)) begin
            exp_q.push_back({8'(x), 7'(y)});
            n_keep++;
        end
    endtask

    task automatic engine_run(input int i, input bit pulse, input int npix, input bit drop_start);
        int waited, x, y;
        bit plot;
        wait_circ_start($sformatf("circ_start_%0d", i), waited);
        if (i > 1) chk($sformatf("gap_len_%0d", i), 32'(waited), 32'd0);
        chk($sformatf("centre_x_%0d", i), 32'(circ_centre_x), 32'(vx[i]));
        chk($sformatf("centre_y_%0d", i), 32'(circ_centre_y), 32'(vy[i]));
        chk($sformatf("radius_%0d", i), 32'(circ_radius), 32'(m_d));
        for (int p = 0; p < npix; p++) begin
            tick();
            if (drop_start && p == 0) start = 1'b0;
            x    = clamp(vx[i] + $urandom_range(2 * m_d, 0) - m_d, 0, 159);
            y    = clamp(vy[i] + $urandom_range(2 * m_d, 0) - m_d, 0, 119);
            plot = $urandom_range(3, 0) != 0;
            // boundary pair on circle 3: exactly d from V2 (kept) and one pixel beyond (dropped)
            if (i == 3 && p < 2 && vx[2] + m_d + p <= 159) begin
                x = vx[2] + m_d + p;
                y = vy[2];
                plot = 1'b1;
            end
            drive_pixel(i, x, y, plot, p == npix - 1);
        end
        tick();
        // engine releases finished once start drops; a stray pixel here must be ignored
        circ_finished = pulse ? 1'b0 : circ_start;
        circ_x        = 8'(vx[i]);
        circ_y        = 7'(vy[i]);
        circ_plot     = 1'b1;
        @(negedge clk);
        chk($sformatf("gap_low_%0d", i), 32'(circ_start), 32'd0);
        circ_plot     = 1'b0;
        circ_finished = 1'b0;
    endtask

    task automatic wait_finished(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (finished === 1'b1 || n >= 200) break;
            n++;
        end
        chk(tag, 32'(finished), 32'd1);
    endtask

    task automatic launch(input int cx, input int cy, input int d);
        model_vertices(cx, cy, d);
        m_colour = 3'($urandom_range(7, 0));
        exp_q.delete();
        n_plot   = 0;
        n_cstart = 0;
        n_keep   = 0;
        tick();
        centre_x = 8'(cx);
        centre_y = 8'(cy);
        diameter = 8'(d);
        colour   = m_colour;
        start    = 1'b1;
    endtask

    task automatic do_run(input int cx, input int cy, input int d, input bit pulse,
                          input bit drop_start, input int npix);
        launch(cx, cy, d);
        if (!m_err) begin
            for (int i = 1; i <= 3; i++) engine_run(i, pulse, npix, drop_start && i == 1);
        end
        wait_finished("finished");
        chk("err", 32'(err), 32'(m_err));
        chk("plot_count", 32'(n_plot), 32'(n_keep));
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        if (m_err) chk("no_circ_start", 32'(n_cstart), 32'd0);
        if (!drop_start) begin
            @(negedge clk);
            chk("finished_held", 32'(finished), 32'd1);
            tick();
            start = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("finished_drop", 32'(finished), 32'd0);
    endtask

    initial begin
        int waited;
        rst           = 1'b1;
        start         = 1'b0;
        colour        = 3'd0;
        centre_x      = 8'd0;
        centre_y      = 8'd0;
        diameter      = 8'd0;
        circ_finished = 1'b0;
        circ_x        = 8'd0;
        circ_y        = 7'd0;
        circ_plot     = 1'b0;
        m_colour      = 3'd0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctl", 32'({finished, err, circ_start, vga_plot, vga_colour, vga_y}), 32'd0);
        chk("reset_dp", {circ_centre_x, circ_centre_y, circ_radius, vga_x}, 32'd0);
        tick();
        rst = 1'b0;

        // T1/T2: centred triangle, engine holds finished until start drops
        do_run(80, 60, 80, 1'b0, 1'b0, 20);
        // T4: same with one-cycle finished pulses
        do_run(80, 60, 80, 1'b1, 1'b0, 20);
        // T3: left vertex off screen
        do_run(10, 60, 80, 1'b1, 1'b0, 20);
        // d = 0: every engine pixel sits on the centre and passes
        do_run(50, 50, 0, 1'b1, 1'b0, 6);
        // T6: start dropped during the first circle
        do_run(80, 60, 80, 1'b0, 1'b1, 12);

        // T5: reset in the middle of the second circle, then a clean full run
        launch(80, 60, 80);
        engine_run(1, 1'b1, 8, 1'b0);
        wait_circ_start("t5_draw2", waited);
        tick();
        drive_pixel(2, vx[2], vy[2] - 10, 1'b1, 1'b0);
        tick();
        circ_plot = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_vga_plot", 32'(vga_plot), 32'd0);
        chk("t5_circ_start", 32'(circ_start), 32'd0);
        chk("t5_finished", 32'(finished), 32'd0);
        chk("t5_exp_q_empty", 32'(exp_q.size()), 32'd0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        do_run(80, 60, 80, 1'b1, 1'b0, 16);

        // randomized geometry; the model decides between a full run and an error run
        for (int r = 0; r < 6; r++)
            do_run($urandom_range(110, 50), $urandom_range(90, 30), $urandom_range(70, 0),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom_range(24, 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
